// File: rtl/eth_unreach_pkg.sv
// Shared constants, frame offsets and FSM encoding for the ICMP unreachable
// transmitter and the RX parser.
package eth_unreach_pkg;

    localparam logic [15:0] ETH_FTYPE_IP      = 16'h0800;
    localparam logic [7:0]  IP_PROTO_ICMP     = 8'h01;
    localparam logic [7:0]  IP_PROTO_UDP      = 8'h11;
    localparam logic [7:0]  ICMP_DEST_UNREACH = 8'h03;
    localparam logic [7:0]  ICMP_PORT_UNREACH = 8'h03;

    localparam int          FRAME_BYTES = 82;
    localparam int          FRAME_BEATS = 11;
    localparam logic [7:0]  LAST_TKEEP  = 8'h03;
    localparam int          PAD_BYTES   = FRAME_BEATS * 8;

    localparam int OFF_ETH_DST   = 0;
    localparam int OFF_ETH_SRC   = 6;
    localparam int OFF_ETH_TYPE  = 12;
    localparam int OFF_IP        = 14;
    localparam int OFF_IP_CSUM   = 24;
    localparam int OFF_ICMP      = 34;
    localparam int OFF_ICMP_CSUM = 36;
    localparam int OFF_IN_IP     = 42;
    localparam int OFF_UDP       = 62;
    localparam int OFF_DNS       = 70;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CSUM,
        ST_SEND
    } state_t;

    // Network order puts the MSB at the lowest byte lane.
    function automatic logic [15:0] bswap16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic [47:0] bswap48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 6; i++) begin
            r[8*i +: 8] = v[8*(5-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/eth_unreach_tx_csum16_fold.sv
// Combinational one's-complement checksum over N 16-bit words:
// adder tree, end-around carry fold, invert.
module csum16_fold
    import eth_unreach_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N*16-1:0] words,
    output logic [15:0]     csum
);

    logic [31:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + {16'h0000, words[i*16 +: 16]};
        end
        fold1 = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
        // A carry out of fold1 leaves a tiny low half, so one more add suffices.
        fold2 = fold1[15:0] + {15'h0000, fold1[16]};
        csum  = ~fold2;
    end

endmodule

// File: rtl/eth_unreach_tx.sv
// ICMP port-unreachable frame generator for the 10G MAC TX stream.
// Define ICMP_CSUM_EN to compute the ICMP checksum (else it is sent as 0).
module eth_unreach_tx
    import eth_unreach_pkg::*;
#(
    parameter logic [47:0] SRC_MAC = 48'h0000_0000_0000,
    parameter logic [31:0] SRC_IP  = 32'hC0A8_0164,
    parameter logic [7:0]  TTL     = 8'd64
) (
    input  logic        clk156,
    input  logic        eth_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [47:0] req_dst_mac,
    input  logic [31:0] req_dst_ip,
    input  logic [31:0] req_orig_src_ip,
    input  logic [31:0] req_orig_dst_ip,
    input  logic [15:0] req_orig_sport,
    input  logic [15:0] req_orig_dport,
    input  logic [15:0] req_dns_qid,
    input  logic [15:0] req_dns_parm,
    input  logic [15:0] req_dns_qcnt,
    input  logic [15:0] req_dns_acnt,
    input  logic [15:0] req_dns_auth,
    input  logic        m_axis_tready,
    output logic        m_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frame_cnt
);

    localparam logic [3:0] NBEATS    = 4'(FRAME_BEATS);
    localparam logic [3:0] LAST_BEAT = 4'(FRAME_BEATS - 1);

    state_t      state_q;
    state_t      state_d;
    logic        csum_cnt;
    logic [3:0]  ld_idx;
    logic [3:0]  beat_idx;
    logic [15:0] ip_id;
    logic [15:0] ip_csum;
    logic [15:0] ip_csum_q;
    logic [15:0] icmp_csum;
    logic [15:0] icmp_csum_q;

    logic [47:0] dst_mac;
    logic [31:0] dst_ip;
    logic [31:0] orig_src;
    logic [31:0] orig_dst;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] qid;
    logic [15:0] parm;
    logic [15:0] qcnt;
    logic [15:0] acnt;
    logic [15:0] auth;

    logic                   accept;
    logic                   hs;
    logic                   done;
    logic [159:0]           ip_words;
    logic [PAD_BYTES*8-1:0] frame;
    logic [63:0]            beat_data;

    assign req_ready    = (state_q == ST_IDLE) && !eth_rst;
    assign accept       = req_valid && req_ready;
    assign hs           = m_axis_tvalid && m_axis_tready;
    assign done         = hs && (beat_idx == LAST_BEAT);
    assign m_axis_tuser = 1'b0;

    assign ip_words = {16'h4500, 16'h0044, ip_id, 16'h0000,
                       TTL, IP_PROTO_ICMP, 16'h0000, SRC_IP, dst_ip};

    csum16_fold #(.N(10)) u_ip_csum (
        .words (ip_words),
        .csum  (ip_csum)
    );

`ifdef ICMP_CSUM_EN
    logic [383:0] icmp_words;

    assign icmp_words = {ICMP_DEST_UNREACH, ICMP_PORT_UNREACH, 16'h0000,
                         32'h0, 16'h4500, 16'h0028, 32'h0,
                         TTL, IP_PROTO_UDP, 16'h0000, orig_src, orig_dst,
                         sport, dport, 16'h0014, 16'h0000,
                         qid, parm, qcnt, acnt, auth, 16'h0000};

    csum16_fold #(.N(24)) u_icmp_csum (
        .words (icmp_words),
        .csum  (icmp_csum)
    );
`else
    assign icmp_csum = 16'h0000;
`endif

    always_comb begin
        frame = '0;
        frame[OFF_ETH_DST*8  +: 48] = bswap48(dst_mac);
        frame[OFF_ETH_SRC*8  +: 48] = bswap48(SRC_MAC);
        frame[OFF_ETH_TYPE*8 +: 16] = bswap16(ETH_FTYPE_IP);
        frame[OFF_IP*8       +: 16] = bswap16(16'h4500);
        frame[(OFF_IP+2)*8   +: 16] = bswap16(16'h0044);
        frame[(OFF_IP+4)*8   +: 16] = bswap16(ip_id);
        frame[(OFF_IP+8)*8   +: 16] = bswap16({TTL, IP_PROTO_ICMP});
        frame[OFF_IP_CSUM*8  +: 16] = bswap16(ip_csum_q);
        frame[(OFF_IP+12)*8  +: 32] = bswap32(SRC_IP);
        frame[(OFF_IP+16)*8  +: 32] = bswap32(dst_ip);
        frame[OFF_ICMP*8     +: 16] = bswap16({ICMP_DEST_UNREACH,
                                               ICMP_PORT_UNREACH});
        frame[OFF_ICMP_CSUM*8 +: 16] = bswap16(icmp_csum_q);
        frame[OFF_IN_IP*8     +: 16] = bswap16(16'h4500);
        frame[(OFF_IN_IP+2)*8 +: 16] = bswap16(16'h0028);
        frame[(OFF_IN_IP+8)*8 +: 16] = bswap16({TTL, IP_PROTO_UDP});
        frame[(OFF_IN_IP+12)*8 +: 32] = bswap32(orig_src);
        frame[(OFF_IN_IP+16)*8 +: 32] = bswap32(orig_dst);
        frame[OFF_UDP*8      +: 16] = bswap16(sport);
        frame[(OFF_UDP+2)*8  +: 16] = bswap16(dport);
        frame[(OFF_UDP+4)*8  +: 16] = bswap16(16'h0014);
        frame[OFF_DNS*8      +: 16] = bswap16(qid);
        frame[(OFF_DNS+2)*8  +: 16] = bswap16(parm);
        frame[(OFF_DNS+4)*8  +: 16] = bswap16(qcnt);
        frame[(OFF_DNS+6)*8  +: 16] = bswap16(acnt);
        frame[(OFF_DNS+8)*8  +: 16] = bswap16(auth);
    end

    assign beat_data = 64'(frame >> {ld_idx, 6'd0});

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_CSUM;
            ST_CSUM: if (csum_cnt)  state_d = ST_SEND;
            ST_SEND: if (done)      state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk156) begin
        if (accept) begin
            dst_mac  <= req_dst_mac;
            dst_ip   <= req_dst_ip;
            orig_src <= req_orig_src_ip;
            orig_dst <= req_orig_dst_ip;
            sport    <= req_orig_sport;
            dport    <= req_orig_dport;
            qid      <= req_dns_qid;
            parm     <= req_dns_parm;
            qcnt     <= req_dns_qcnt;
            acnt     <= req_dns_acnt;
            auth     <= req_dns_auth;
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state_q       <= ST_IDLE;
            csum_cnt      <= 1'b0;
            ld_idx        <= '0;
            beat_idx      <= '0;
            ip_id         <= '0;
            frame_cnt     <= '0;
            ip_csum_q     <= '0;
            icmp_csum_q   <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    csum_cnt <= 1'b0;
                    ld_idx   <= '0;
                    beat_idx <= '0;
                end
                ST_CSUM: begin
                    csum_cnt    <= 1'b1;
                    ip_csum_q   <= ip_csum;
                    icmp_csum_q <= icmp_csum;
                end
                ST_SEND: begin
                    if (hs) beat_idx <= beat_idx + 4'd1;
                    // Output register refills only when empty or draining.
                    if (!m_axis_tvalid || m_axis_tready) begin
                        if (ld_idx < NBEATS) begin
                            m_axis_tvalid <= 1'b1;
                            m_axis_tdata  <= beat_data;
                            m_axis_tkeep  <= (ld_idx == LAST_BEAT) ?
                                             LAST_TKEEP : 8'hFF;
                            m_axis_tlast  <= (ld_idx == LAST_BEAT);
                            ld_idx        <= ld_idx + 4'd1;
                        end else begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tkeep  <= '0;
                            m_axis_tlast  <= 1'b0;
                        end
                    end
                    if (done) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        ip_id     <= ip_id + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_unreach_tx.sv
// Randomized self-checking bench for eth_unreach_tx against a byte-level
// frame model built from the field layout.
module tb_eth_unreach_tx;

    logic        clk156 = 1'b0;
    logic        eth_rst;
    logic        req_valid;
    logic        req_ready;
    logic [47:0] req_dst_mac;
    logic [31:0] req_dst_ip;
    logic [31:0] req_orig_src_ip;
    logic [31:0] req_orig_dst_ip;
    logic [15:0] req_orig_sport;
    logic [15:0] req_orig_dport;
    logic [15:0] req_dns_qid;
    logic [15:0] req_dns_parm;
    logic [15:0] req_dns_qcnt;
    logic [15:0] req_dns_acnt;
    logic [15:0] req_dns_auth;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic [15:0] frame_cnt;

    always #5 clk156 = ~clk156;

    eth_unreach_tx dut (
        .clk156          (clk156),
        .eth_rst         (eth_rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dst_mac     (req_dst_mac),
        .req_dst_ip      (req_dst_ip),
        .req_orig_src_ip (req_orig_src_ip),
        .req_orig_dst_ip (req_orig_dst_ip),
        .req_orig_sport  (req_orig_sport),
        .req_orig_dport  (req_orig_dport),
        .req_dns_qid     (req_dns_qid),
        .req_dns_parm    (req_dns_parm),
        .req_dns_qcnt    (req_dns_qcnt),
        .req_dns_acnt    (req_dns_acnt),
        .req_dns_auth    (req_dns_auth),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tuser    (m_axis_tuser),
        .frame_cnt       (frame_cnt)
    );

    typedef struct {
        logic [47:0] mac;
        logic [31:0] dip;
        logic [31:0] osrc;
        logic [31:0] odst;
        logic [15:0] sport;
        logic [15:0] dport;
        logic [15:0] qid;
        logic [15:0] parm;
        logic [15:0] qcnt;
        logic [15:0] acnt;
        logic [15:0] auth;
    } req_t;

    int checks = 0;
    int passed = 0;

    logic [15:0] exp_id;
    logic [15:0] exp_cnt;
    logic [7:0]  exp_f [82];
    logic [7:0]  got_f [88];
    int          nbeats;
    int          first_n;
    int          bad_keep;
    int          bad_last;
    int          bad_hold;
    bit          timed_out;
    int          waited;

    function automatic req_t rand_req();
        req_t r;
        r.mac   = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        r.dip   = $urandom;
        r.osrc  = $urandom;
        r.odst  = $urandom;
        r.sport = 16'($urandom);
        r.dport = 16'($urandom);
        r.qid   = 16'($urandom);
        r.parm  = 16'($urandom);
        r.qcnt  = 16'($urandom);
        r.acnt  = 16'($urandom);
        r.auth  = 16'($urandom);
        return r;
    endfunction

    task automatic apply_req(input req_t r);
        req_dst_mac     = r.mac;
        req_dst_ip      = r.dip;
        req_orig_src_ip = r.osrc;
        req_orig_dst_ip = r.odst;
        req_orig_sport  = r.sport;
        req_orig_dport  = r.dport;
        req_dns_qid     = r.qid;
        req_dns_parm    = r.parm;
        req_dns_qcnt    = r.qcnt;
        req_dns_acnt    = r.acnt;
        req_dns_auth    = r.auth;
    endtask

    task automatic put(input int off, input int n, input logic [47:0] v);
        for (int i = 0; i < n; i++) exp_f[off+i] = v[8*(n-1-i) +: 8];
    endtask

    function automatic logic [15:0] ones_csum(input int a, input int b);
        int unsigned s = 0;
        for (int i = a; i < b; i += 2) s += {exp_f[i], exp_f[i+1]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        return ~s[15:0];
    endfunction

    task automatic model_frame(input req_t r, input logic [15:0] id);
        for (int i = 0; i < 82; i++) exp_f[i] = 8'h00;
        put(0, 6, r.mac);
        put(6, 6, 48'h0);
        put(12, 2, 48'h0800);
        put(14, 4, 48'h4500_0044);
        put(18, 2, {32'h0, id});
        put(22, 2, 48'h4001);
        put(26, 4, 48'hC0A8_0164);
        put(30, 4, {16'h0, r.dip});
        put(34, 2, 48'h0303);
        put(42, 4, 48'h4500_0028);
        put(50, 2, 48'h4011);
        put(54, 4, {16'h0, r.osrc});
        put(58, 4, {16'h0, r.odst});
        put(62, 2, {32'h0, r.sport});
        put(64, 2, {32'h0, r.dport});
        put(66, 2, 48'h0014);
        put(70, 2, {32'h0, r.qid});
        put(72, 2, {32'h0, r.parm});
        put(74, 2, {32'h0, r.qcnt});
        put(76, 2, {32'h0, r.acnt});
        put(78, 2, {32'h0, r.auth});
        put(24, 2, {32'h0, ones_csum(14, 34)});
`ifdef ICMP_CSUM_EN
        put(36, 2, {32'h0, ones_csum(34, 82)});
`endif
    endtask

    task automatic wait_accept();
        waited = -1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                @(posedge clk156);
                waited = i;
                return;
            end
            @(negedge clk156);
        end
    endtask

    task automatic collect(input int stall_beat, input int stall_len);
        int n = 0;
        int stalls = 0;
        logic [63:0] hd;
        logic [7:0] hk;
        logic hl;
        nbeats = 0; first_n = -1; bad_keep = 0; bad_last = 0;
        bad_hold = 0; timed_out = 1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk156);
            n++;
            if (m_axis_tvalid && first_n < 0) first_n = n;
            if (!m_axis_tvalid) begin
                m_axis_tready = 1'b1;
            end else if (nbeats == stall_beat && stalls < stall_len) begin
                if (stalls == 0) begin
                    hd = m_axis_tdata; hk = m_axis_tkeep; hl = m_axis_tlast;
                end else if (m_axis_tdata !== hd || m_axis_tkeep !== hk ||
                             m_axis_tlast !== hl) begin
                    bad_hold++;
                end
                m_axis_tready = 1'b0;
                stalls++;
            end else begin
                if (stall_len > 0 && nbeats == stall_beat &&
                    (m_axis_tdata !== hd || m_axis_tkeep !== hk)) bad_hold++;
                m_axis_tready = 1'b1;
                for (int k = 0; k < 8; k++)
                    got_f[nbeats*8+k] = m_axis_tdata[8*k +: 8];
                if (m_axis_tkeep !== ((nbeats == 10) ? 8'h03 : 8'hFF))
                    bad_keep++;
                if (m_axis_tlast !== (nbeats == 10)) bad_last++;
                nbeats++;
                if (m_axis_tlast || nbeats == 11) begin
                    timed_out = 0;
                    break;
                end
            end
        end
    endtask

    // One complete request/frame with optional stall and held-valid follow-on.
    task automatic test_frame(input string nm, input req_t r,
                              input int stall_beat, input int stall_len,
                              input bit hold, input req_t nxt);
        int bad_bytes = 0;
        int bidx = -1;
        apply_req(r);
        req_valid = 1'b1;
        wait_accept();
        checks++;
        if (waited < 0) $display("FAIL %s accept: got timeout required ready", nm);
        else passed++;
        #1;
        if (hold) apply_req(nxt);
        else req_valid = 1'b0;
        model_frame(r, exp_id);
        collect(stall_beat, stall_len);
        checks++;
        if (timed_out) $display("FAIL %s end: got timeout required tlast", nm);
        else passed++;
        @(posedge clk156);
        exp_id++;
        exp_cnt++;
        @(negedge clk156);
        checks++;
        if (first_n !== 4)
            $display("FAIL %s latency: got %0d required 4", nm, first_n);
        else passed++;
        checks++;
        if (nbeats !== 11)
            $display("FAIL %s beats: got %0d required 11", nm, nbeats);
        else passed++;
        checks++;
        if (bad_keep !== 0 || bad_last !== 0)
            $display("FAIL %s keep/last: got %0d/%0d bad required 0/0",
                     nm, bad_keep, bad_last);
        else passed++;
        if (stall_len > 0) begin
            checks++;
            if (bad_hold !== 0)
                $display("FAIL %s hold: got %0d changes required 0", nm, bad_hold);
            else passed++;
        end
        for (int i = 0; i < 82; i++) begin
            if (got_f[i] !== exp_f[i]) begin
                bad_bytes++;
                if (bidx < 0) bidx = i;
            end
        end
        checks++;
        if (bad_bytes !== 0)
            $display("FAIL %s bytes: %0d wrong, byte %0d got %02h required %02h",
                     nm, bad_bytes, bidx, got_f[bidx], exp_f[bidx]);
        else passed++;
        checks++;
        if (frame_cnt !== exp_cnt)
            $display("FAIL %s frame_cnt: got %0d required %0d", nm, frame_cnt, exp_cnt);
        else passed++;
        checks++;
        if (req_ready !== 1'b1 || m_axis_tvalid !== 1'b0)
            $display("FAIL %s idle: got ready=%b tvalid=%b required 1/0",
                     nm, req_ready, m_axis_tvalid);
        else passed++;
    endtask

    task automatic test_reset();
        eth_rst = 1'b1;
        repeat (3) @(posedge clk156);
        @(negedge clk156);
        checks++;
        if (req_ready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0)
            $display("FAIL reset ctl: got ready=%b tvalid=%b tlast=%b required 0/0/0",
                     req_ready, m_axis_tvalid, m_axis_tlast);
        else passed++;
        checks++;
        if (m_axis_tdata !== 64'h0 || m_axis_tkeep !== 8'h0 || frame_cnt !== 16'h0)
            $display("FAIL reset data: got %h/%h/%0d required 0/0/0",
                     m_axis_tdata, m_axis_tkeep, frame_cnt);
        else passed++;
        eth_rst = 1'b0;
        @(negedge clk156);
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL reset ready: got %b required 1", req_ready);
        else passed++;
        exp_id = 0;
        exp_cnt = 0;
    endtask

    task automatic test_single();
        req_t r = rand_req();
        r.dip = 32'hC0A8_0162;
        test_frame("single", r, -1, 0, 0, r);
        checks++;
        if ({got_f[24], got_f[25]} !== 16'hF6A2)
            $display("FAIL single ipcsum: got %h required f6a2", {got_f[24], got_f[25]});
        else passed++;
`ifndef ICMP_CSUM_EN
        checks++;
        if ({got_f[36], got_f[37]} !== 16'h0000)
            $display("FAIL single icmpcsum: got %h required 0000", {got_f[36], got_f[37]});
        else passed++;
`endif
    endtask

    task automatic test_backpressure();
        test_frame("stall", rand_req(), 4, 5, 0, rand_req());
    endtask

    task automatic test_back_to_back();
        req_t a = rand_req();
        req_t b = rand_req();
        test_frame("b2b_first", a, -1, 0, 1, b);
        test_frame("b2b_second", b, -1, 0, 0, b);
        checks++;
        if (waited !== 0)
            $display("FAIL b2b gap: got %0d idle cycles required 0", waited);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        int lasts = 0;
        apply_req(rand_req());
        req_valid = 1'b1;
        wait_accept();
        #1 req_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk156);
            if (m_axis_tvalid) begin
                if (seen == 6) break;
                if (m_axis_tlast) lasts++;
                seen++;
            end
        end
        checks++;
        if (seen !== 6 || lasts !== 0)
            $display("FAIL midrst reach: got %0d beats %0d tlast required 6 0",
                     seen, lasts);
        else passed++;
        eth_rst = 1'b1;
        @(posedge clk156);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || frame_cnt !== 16'h0)
            $display("FAIL midrst clear: got tvalid=%b cnt=%0d required 0/0",
                     m_axis_tvalid, frame_cnt);
        else passed++;
        @(negedge clk156);
        eth_rst = 1'b0;
        exp_id = 0;
        exp_cnt = 0;
        @(negedge clk156);
        checks++;
        if (req_ready !== 1'b1)
            $display("FAIL midrst ready: got %b required 1", req_ready);
        else passed++;
        test_frame("after_rst", rand_req(), -1, 0, 0, rand_req());
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            test_frame("random", rand_req(), $urandom_range(0, 10),
                       $urandom_range(0, 4), 0, rand_req());
        end
    endtask

    initial begin
        eth_rst       = 1'b1;
        req_valid     = 1'b0;
        m_axis_tready = 1'b1;
        apply_req(rand_req());
        exp_id  = 0;
        exp_cnt = 0;
        @(negedge clk156);
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
